vp_sequencer: RTL

Controller that loads and runs programs on vertex_processor.
- Accepts program words from a host valid/ready stream and writes them into the processor's instruction memory.
- On start, runs the loaded program once per vertex for a host-specified vertex count.
- vertex_processor takes its fetch address directly from addr_ins_m, so this block also acts as the program counter source. It drives the address during load (write pointer) and during run (fetch counter).

---
 rtl/vp_sequencer_if.sv | 12 +
 rtl/vp_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vp_sequencer_if.sv
// Host program-load stream: valid/ready word transfer with an end-of-program marker.
interface vp_sequencer_if #(
    parameter int unsigned ins_data_w = 60
);
    logic                  ld_valid;
    logic                  ld_ready;
    logic [ins_data_w-1:0] ld_data;
    logic                  ld_last;

    modport master (output ld_valid, output ld_data, output ld_last, input  ld_ready);
    modport slave  (input  ld_valid, input  ld_data, input  ld_last, output ld_ready);
endinterface

// File: rtl/vp_sequencer.sv
// Loads programs into vertex_processor instruction memory and runs them once per vertex,
// acting as the processor's fetch-address source during load and run.
module vp_sequencer #(
    parameter int unsigned pc_ins_addr_w = 8,
    parameter int unsigned ins_data_w    = 60,
    parameter int unsigned vtx_cnt_w     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    vp_sequencer_if.slave            ld,
    input  logic                     start,
    input  logic                     abort,
    input  logic [pc_ins_addr_w-1:0] prog_len,
    input  logic [vtx_cnt_w-1:0]     vtx_count,
    output logic                     vp_enable,
    output logic                     vp_reset,
    output logic                     vp_we_ins_m,
    output logic [pc_ins_addr_w-1:0] vp_addr_ins_m,
    output logic [ins_data_w-1:0]    vp_din_ins_m,
    output logic                     busy,
    output logic [vtx_cnt_w-1:0]     vtx_idx,
    output logic                     done,
    output logic                     err
);

    localparam logic [pc_ins_addr_w-1:0] addr_max = '1;
    localparam logic [pc_ins_addr_w-1:0] addr_one = pc_ins_addr_w'(1);
    localparam logic [vtx_cnt_w-1:0]     vtx_one  = vtx_cnt_w'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [pc_ins_addr_w-1:0] ptr_q, ptr_d;
    logic [pc_ins_addr_w-1:0] loaded_len_q, loaded_len_d;
    logic                     prog_loaded_q, prog_loaded_d;
    logic                     ld_full_q, ld_full_d;
    logic [pc_ins_addr_w-1:0] len_q, len_d;
    logic [vtx_cnt_w-1:0]     cnt_q, cnt_d;

    logic                     enable_d, clr_d, we_d, busy_d, done_d, err_d;
    logic [pc_ins_addr_w-1:0] addr_d;
    logic [ins_data_w-1:0]    din_d;
    logic [vtx_cnt_w-1:0]     idx_d;

    logic ld_ready_c;
    logic accept_c;

    // A forced (full-memory) load spends one extra LOAD cycle with ready low while the last word lands.
    assign ld_ready_c  = (state_q == S_IDLE) || ((state_q == S_LOAD) && !ld_full_q);
    assign ld.ld_ready = ld_ready_c;
    assign accept_c    = ld.ld_valid && ld_ready_c;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        loaded_len_d  = loaded_len_q;
        prog_loaded_d = prog_loaded_q;
        ld_full_d     = ld_full_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        we_d          = 1'b0;
        addr_d        = '0;
        din_d         = vp_din_ins_m;
        idx_d         = vtx_idx;
        err_d         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    we_d   = 1'b1;
                    addr_d = ptr_q;
                    din_d  = ld.ld_data;
                    if (ld.ld_last) begin
                        loaded_len_d  = addr_one;
                        prog_loaded_d = 1'b1;
                        ptr_d         = '0;
                    end else begin
                        ptr_d   = ptr_q + addr_one;
                        state_d = S_LOAD;
                    end
                end else if (start) begin
                    if (!prog_loaded_q || (prog_len == '0) || (vtx_count == '0) ||
                        (prog_len > loaded_len_q)) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = prog_len;
                        cnt_d   = vtx_count;
                        idx_d   = '0;
                        state_d = S_CLR;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    prog_loaded_d = 1'b0;
                    ld_full_d     = 1'b0;
                    ptr_d         = '0;
                    state_d       = S_IDLE;
                end else if (ld_full_q) begin
                    loaded_len_d  = addr_max;
                    prog_loaded_d = 1'b1;
                    ld_full_d     = 1'b0;
                    ptr_d         = '0;
                    state_d       = S_IDLE;
                end else if (accept_c) begin
                    we_d   = 1'b1;
                    addr_d = ptr_q;
                    din_d  = ld.ld_data;
                    if (ld.ld_last) begin
                        loaded_len_d  = (ptr_q == addr_max) ? addr_max : ptr_q + addr_one;
                        prog_loaded_d = 1'b1;
                        ptr_d         = '0;
                        state_d       = S_IDLE;
                    end else if (ptr_q == addr_max) begin
                        ld_full_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + addr_one;
                    end
                end
            end
            S_CLR: begin
                state_d = abort ? S_IDLE : S_RUN;
            end
            // The registered address output doubles as the fetch counter.
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (vp_addr_ins_m == len_q - addr_one) begin
                    state_d = S_NEXT;
                end else begin
                    addr_d = vp_addr_ins_m + addr_one;
                end
            end
            S_NEXT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (vtx_idx == cnt_q - vtx_one) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = vtx_idx + vtx_one;
                    state_d = S_CLR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        enable_d = (state_d == S_RUN);
        clr_d    = (state_d == S_CLR);
        busy_d   = (state_d == S_CLR) || (state_d == S_RUN) || (state_d == S_NEXT);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            loaded_len_q  <= '0;
            prog_loaded_q <= 1'b0;
            ld_full_q     <= 1'b0;
            len_q         <= '0;
            cnt_q         <= '0;
            vp_enable     <= 1'b0;
            vp_reset      <= 1'b0;
            vp_we_ins_m   <= 1'b0;
            vp_addr_ins_m <= '0;
            vp_din_ins_m  <= '0;
            busy          <= 1'b0;
            vtx_idx       <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            loaded_len_q  <= loaded_len_d;
            prog_loaded_q <= prog_loaded_d;
            ld_full_q     <= ld_full_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            vp_enable     <= enable_d;
            vp_reset      <= clr_d;
            vp_we_ins_m   <= we_d;
            vp_addr_ins_m <= addr_d;
            vp_din_ins_m  <= din_d;
            busy          <= busy_d;
            vtx_idx       <= idx_d;
            done          <= done_d;
            err           <= err_d;
        end
    end

endmodule
